uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one UART transmitter (2..8).
REQ-002 SHALL have parameter PAYLOAD_BITS, default 8, bits per UART byte.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester byte available.
REQ-006 SHALL have port req_data  input  NUM_REQ*PAYLOAD_BITS  per-requester byte; requester k at bits [k*PAYLOAD_BITS +: PAYLOAD_BITS].
REQ-007 SHALL have port req_last  input  NUM_REQ  marks last byte of a message; used only when UART_ARB_LOCK_EN is defined.
REQ-008 SHALL have port req_ready  output  NUM_REQ  one-cycle pulse; byte of that requester accepted.
REQ-009 SHALL have port uart_tx_en  output  1  one-cycle start pulse to the UART transmitter.
REQ-010 SHALL have port uart_tx_data  output  PAYLOAD_BITS  byte to the transmitter, held stable from the start pulse until return to IDLE.
REQ-011 SHALL have port uart_tx_busy  input  1  transmitter busy.
REQ-012 SHALL have port grant_id  output  clog2(NUM_REQ)  index of the most recently accepted requester.
REQ-013 SHALL have port arb_busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, SEND, WAIT_HI, WAIT_LO.
REQ-015 IDLE: if any eligible req_valid and uart_tx_busy==0, SHALL pick the winner, pulse its req_ready, latch its byte into uart_tx_data, set grant_id, and go to SEND; otherwise stay in IDLE.
REQ-016 SEND: SHALL assert uart_tx_en for exactly one cycle, then go to WAIT_HI.
REQ-017 WAIT_HI: SHALL wait until uart_tx_busy==1, then go to WAIT_LO.
REQ-018 WAIT_LO: SHALL wait until uart_tx_busy==0, then go to IDLE.
REQ-019 Latency SHALL be: req_valid seen in IDLE at cycle N gives req_ready at N and uart_tx_en at N+1.
REQ-020 Arbitration SHALL be round-robin; search starts at grant_id+1 modulo NUM_REQ, wrapping from NUM_REQ-1 to 0.
REQ-021 The round-robin pointer SHALL update only on acceptance; requests arriving outside IDLE are held off (req_ready stays 0).
REQ-022 At most one req_ready bit SHALL be high in any cycle.
REQ-023 A requester dropping req_valid before acceptance SHALL never be granted; the search skips it without penalty.
REQ-024 If uart_tx_busy==1 while in IDLE, the FSM SHALL NOT grant until it falls.

Reset
REQ-025 Reset SHALL give FSM=IDLE, uart_tx_en=0, uart_tx_data=0, req_ready=0, arb_busy=0, grant_id=NUM_REQ-1 (requester 0 wins first), lock cleared.
REQ-026 Reset asserted mid-transfer SHALL abandon the transfer immediately with no further uart_tx_en pulse.

Configuration
REQ-027 Macro UART_ARB_LOCK_EN defined: after a byte is accepted with req_last==0, only that requester SHALL be eligible until a byte with req_last==1 is accepted; then round-robin resumes from it.
REQ-028 Macro UART_ARB_LOCK_EN undefined: req_last SHALL be ignored and every byte arbitrated independently; no lock register is built.

Structure
REQ-029 FSM state encoding and default parameter constants SHALL live in shared package uart_pkg.
REQ-030 The rotate-and-priority-encode winner selection SHALL be sub-module uart_rr_pick (inputs: request vector, last grant; output: one-hot winner, valid).

Verification
REQ-031 Single requester 2, data 0xA5, busy pulses high 3 cycles after start -> req_ready[2] at N, uart_tx_en at N+1 with data 0xA5, arb_busy low after busy falls.
REQ-032 All four valid continuously with distinct data -> grant order 0,1,2,3,0; one uart_tx_en per byte.
REQ-033 Requests 1 and 3 valid after last grant 3 -> requester 1 wins; next is 3.
REQ-034 uart_tx_busy held high in IDLE with req_valid[0]=1 -> no req_ready until busy falls; grant one cycle after the fall is sampled.
REQ-035 UART_ARB_LOCK_EN: requester 1 sends 3 bytes, last on 3rd, requester 0 valid throughout -> bytes 1,1,1 then 0; without macro -> 1,0,1,0 interleave.
REQ-036 resetn asserted in WAIT_LO -> all outputs at reset values next edge; first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART transmit arbiter.
package uart_pkg;

    localparam int UART_NUM_REQ_DEF      = 4;
    localparam int UART_PAYLOAD_BITS_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin winner selection: search starts one past the last grant and wraps.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = UART_NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       valid
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first; a path that skips an assignment infers a latch.
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = ID_W'((int'(last_grant) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign valid = found;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Optional message lock (a requester keeps the grant until req_last) enabled by UART_ARB_LOCK_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = UART_NUM_REQ_DEF,
    parameter int PAYLOAD_BITS = UART_PAYLOAD_BITS_DEF
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            uart_tx_en,
    output logic [PAYLOAD_BITS-1:0]         uart_tx_data,
    input  logic                            uart_tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            arb_busy
);

    localparam int ID_W = $clog2(NUM_REQ);

    arb_state_t          state;
    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  win_onehot;
    logic                win_valid;
    logic                accept;
    logic [ID_W-1:0]     win_id;

`ifdef UART_ARB_LOCK_EN
    // While a message is open only its owner (the last grantee) may compete.
    logic lock_q;

    always_comb begin
        eligible = req_valid;
        if (lock_q) eligible = req_valid & (NUM_REQ'(1) << grant_id);
    end
`else
    logic unused_last;

    assign eligible    = req_valid;
    assign unused_last = ^req_last;
`endif

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req        (eligible),
        .last_grant (grant_id),
        .grant      (win_onehot),
        .valid      (win_valid)
    );

    // Acceptance is combinational so req_ready lands in the same cycle the request is seen.
    assign accept    = resetn && (state == IDLE) && !uart_tx_busy && win_valid;
    assign req_ready = accept ? win_onehot : {NUM_REQ{1'b0}};

    always_comb begin
        win_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_onehot[i]) win_id = ID_W'(i);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            uart_tx_en   <= 1'b0;
            uart_tx_data <= '0;
            grant_id     <= ID_W'(NUM_REQ - 1);
            arb_busy     <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            lock_q       <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            uart_tx_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state        <= SEND;
                        uart_tx_en   <= 1'b1;
                        uart_tx_data <= req_data[win_id*PAYLOAD_BITS +: PAYLOAD_BITS];
                        grant_id     <= win_id;
                        arb_busy     <= 1'b1;
`ifdef UART_ARB_LOCK_EN
                        lock_q       <= !req_last[win_id];
`endif
                    end
                end
                SEND:    state <= WAIT_HI;
                WAIT_HI: if (uart_tx_busy) state <= WAIT_LO;
                WAIT_LO: begin
                    if (!uart_tx_busy) begin
                        state    <= IDLE;
                        arb_busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: transaction-level reference model plus directed pins.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int PB = 8;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*PB-1:0] req_data = '0;
    logic [N-1:0]    req_last = '0;
    logic [N-1:0]    req_ready;
    logic            uart_tx_en;
    logic [PB-1:0]   uart_tx_data;
    logic            uart_tx_busy = 1'b0;
    logic [1:0]      grant_id;
    logic            arb_busy;

    uart_tx_arbiter #(.NUM_REQ(N), .PAYLOAD_BITS(PB)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_data (uart_tx_data),
        .uart_tx_busy (uart_tx_busy),
        .grant_id     (grant_id),
        .arb_busy     (arb_busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // stimulus state
    logic [N-1:0]  drv_valid = '0;
    logic [N-1:0]  drv_last = '0;
    logic [PB-1:0] drv_data [N];
    int            rem [N];
    bit            rand_mode = 0;
    bit            msg_mode = 0;
    bit            drv_rst = 1;
    bit            force_busy = 0;
    int            tx_wait = 0, tx_hold = 0;
    int            tx_wait_cfg = 1, tx_hold_cfg = 2;

    // observations
    logic [N-1:0]  obs_ready = '0;
    int            grant_q[$];
    logic [PB-1:0] en_data_q[$];
    int            cyc = 0, grant_cyc = 0, en_cyc = 0;

    // reference model: transaction view (idle / age since acceptance / busy-high seen)
    int            m_grant, m_lock, m_age, m_win;
    logic [PB-1:0] m_data;
    bit            m_idle, m_hi;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: cycle budget expired (t=%0t)", name, $time);
    endtask

    function automatic int q_at(input int i);
        return (i < grant_q.size()) ? grant_q[i] : -1;
    endfunction

    function automatic void model_reset();
        m_grant = N - 1;
        m_lock  = -1;
        m_data  = '0;
        m_idle  = 1;
        m_hi    = 0;
        m_age   = 0;
        m_win   = -1;
    endfunction

    function automatic int model_pick();
        for (int i = 1; i <= N; i++) begin
            int k = (m_grant + i) % N;
            if (drv_valid[k] && (m_lock < 0 || m_lock == k)) return k;
        end
        return -1;
    endfunction

    function automatic void model_update();
        if (m_idle) begin
            if (m_win >= 0) begin
                m_grant = m_win;
                m_data  = drv_data[m_win];
                m_idle  = 0;
                m_age   = 1;
                m_hi    = 0;
`ifdef UART_ARB_LOCK_EN
                m_lock  = drv_last[m_win] ? -1 : m_win;
`endif
            end
        end else begin
            if (m_age >= 2) begin
                if (!m_hi) begin
                    if (uart_tx_busy) m_hi = 1;
                end else if (!uart_tx_busy) begin
                    m_idle = 1;
                end
            end
            m_age++;
        end
    endfunction

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic set_counted(input int k, input int n);
        rem[k]       = n;
        drv_data[k]  = PB'(k * 16 + n);
        drv_valid[k] = (n > 0);
        drv_last[k]  = msg_mode ? (n == 1) : 1'b1;
    endtask

    task automatic clear_reqs();
        for (int k = 0; k < N; k++) set_counted(k, 0);
    endtask

    task automatic drive_requesters();
        for (int k = 0; k < N; k++) begin
            if (rand_mode) begin
                if (obs_ready[k]) begin
                    drv_data[k]  = PB'($urandom);
                    drv_valid[k] = ($urandom_range(0, 3) != 0);
                    drv_last[k]  = ($urandom_range(0, 1) == 0);
                end else if (drv_valid[k]) begin
                    if ($urandom_range(0, 15) == 0) drv_valid[k] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    drv_valid[k] = 1'b1;
                    drv_data[k]  = PB'($urandom);
                    drv_last[k]  = ($urandom_range(0, 1) == 0);
                end
            end else begin
                if (obs_ready[k] && rem[k] > 0) begin
                    rem[k]--;
                    drv_data[k] = PB'(k * 16 + rem[k]);
                end
                drv_valid[k] = (rem[k] > 0);
                drv_last[k]  = msg_mode ? (rem[k] == 1) : 1'b1;
            end
        end
    endtask

    // One clock: drive at negedge, compare 1 time unit later, advance the model at posedge.
    task automatic cycle();
        logic [N-1:0] exp_ready;
        @(negedge clk);
        cyc++;
        drive_requesters();
        if (force_busy) begin
            uart_tx_busy = 1'b1;
        end else if (tx_wait > 0) begin
            uart_tx_busy = 1'b0;
            tx_wait--;
        end else if (tx_hold > 0) begin
            uart_tx_busy = 1'b1;
            tx_hold--;
        end else begin
            uart_tx_busy = 1'b0;
            if (rand_mode && $urandom_range(0, 24) == 0) tx_hold = $urandom_range(1, 3);
        end
        resetn    = ~drv_rst;
        req_valid = drv_valid;
        req_last  = drv_last;
        for (int k = 0; k < N; k++) req_data[k*PB +: PB] = drv_data[k];
        #1;
        if (drv_rst) model_reset();
        else m_win = (m_idle && !uart_tx_busy) ? model_pick() : -1;
        exp_ready = (m_win >= 0) ? N'(1) << m_win : '0;

        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
        check("uart_tx_en", 32'(uart_tx_en), 32'(!m_idle && m_age == 1));
        check("uart_tx_data", 32'(uart_tx_data), 32'(m_data));
        check("grant_id", 32'(grant_id), 32'(m_grant));
        check("arb_busy", 32'(arb_busy), 32'(!m_idle));

        obs_ready = req_ready;
        if (req_ready != '0) begin
            grant_q.push_back(oh_idx(req_ready));
            grant_cyc = cyc;
        end
        if (uart_tx_en) begin
            en_data_q.push_back(uart_tx_data);
            en_cyc  = cyc;
            tx_wait = rand_mode ? $urandom_range(0, 2) : tx_wait_cfg;
            tx_hold = rand_mode ? $urandom_range(1, 4) : tx_hold_cfg;
        end
        if (drv_rst) begin
            tx_wait = 0;
            tx_hold = 0;
        end
        @(posedge clk);
        if (!drv_rst) model_update();
    endtask

    task automatic run_grants(input int n, input int budget, input string name);
        int c = 0;
        while (grant_q.size() < n && c < budget) begin
            cycle();
            c++;
        end
        if (grant_q.size() < n) timeout(name);
    endtask

    task automatic drain(input string name);
        int c = 0;
        clear_reqs();
        while (!m_idle && c < 100) begin
            cycle();
            c++;
        end
        if (!m_idle) timeout(name);
        cycle();
    endtask

    task automatic start_test();
        grant_q.delete();
        en_data_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            drv_data[k] = '0;
            rem[k]      = 0;
        end
        model_reset();

        // reset state
        drv_rst = 1;
        cycle();
        cycle();
        #1;
        check("rst_grant_id", 32'(grant_id), 32'd3);
        check("rst_tx_data", 32'(uart_tx_data), 32'h0);
        check("rst_arb_busy", 32'(arb_busy), 32'd0);
        drv_rst = 0;
        cycle();

        // all four continuously valid: 0,1,2,3,0, one start pulse per byte
        start_test();
        set_counted(0, 2); set_counted(1, 1); set_counted(2, 1); set_counted(3, 1);
        run_grants(5, 200, "rr_all");
        drain("rr_all_drain");
        check("rr_all_g0", 32'(q_at(0)), 32'd0);
        check("rr_all_g1", 32'(q_at(1)), 32'd1);
        check("rr_all_g2", 32'(q_at(2)), 32'd2);
        check("rr_all_g3", 32'(q_at(3)), 32'd3);
        check("rr_all_g4", 32'(q_at(4)), 32'd0);
        check("rr_all_en_count", 32'(en_data_q.size()), 32'd5);
        if (en_data_q.size() == 5) begin
            check("rr_all_d0", 32'(en_data_q[0]), 32'h02);
            check("rr_all_d4", 32'(en_data_q[4]), 32'h01);
        end

        // transmitter busy while idle holds off the grant
        start_test();
        force_busy = 1;
        set_counted(0, 1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("stall_no_ready", 32'(obs_ready), 32'h0);
        end
        force_busy = 0;
        cycle();
        check("stall_ready_after_fall", 32'(obs_ready), 32'h1);
        drain("stall_drain");

        // single requester 2 with 0xA5, busy rising 3 cycles after start
        start_test();
        tx_wait_cfg = 2;
        tx_hold_cfg = 2;
        set_counted(2, 1);
        drv_data[2] = 8'hA5;
        run_grants(1, 50, "single");
        drain("single_drain");
        check("single_winner", 32'(q_at(0)), 32'd2);
        check("single_en_latency", 32'(en_cyc - grant_cyc), 32'd1);
        check("single_data", 32'(en_data_q.size() > 0 ? en_data_q[0] : 8'h00), 32'hA5);
        check("single_grant_id", 32'(grant_id), 32'd2);
        check("single_idle", 32'(arb_busy), 32'd0);
        tx_wait_cfg = 1;

        // after last grant 3, requests 1 and 3 -> 1 then 3
        start_test();
        set_counted(3, 1);
        run_grants(1, 50, "wrap_pre");
        drain("wrap_pre_drain");
        start_test();
        set_counted(1, 1); set_counted(3, 1);
        run_grants(2, 100, "wrap");
        drain("wrap_drain");
        check("wrap_first", 32'(q_at(0)), 32'd1);
        check("wrap_second", 32'(q_at(1)), 32'd3);

        // message lock: requester 1 sends 3 bytes (last on 3rd), requester 0 valid throughout
        start_test();
        set_counted(0, 1);
        run_grants(1, 50, "lock_pre");
        drain("lock_pre_drain");
        start_test();
        msg_mode = 1;
        set_counted(1, 3); set_counted(0, 100);
        run_grants(4, 200, "lock");
        drain("lock_drain");
        msg_mode = 0;
`ifdef UART_ARB_LOCK_EN
        check("lock_g0", 32'(q_at(0)), 32'd1);
        check("lock_g1", 32'(q_at(1)), 32'd1);
        check("lock_g2", 32'(q_at(2)), 32'd1);
        check("lock_g3", 32'(q_at(3)), 32'd0);
`else
        check("lock_g0", 32'(q_at(0)), 32'd1);
        check("lock_g1", 32'(q_at(1)), 32'd0);
        check("lock_g2", 32'(q_at(2)), 32'd1);
        check("lock_g3", 32'(q_at(3)), 32'd0);
`endif

        // reset asserted while waiting for busy to fall
        start_test();
        tx_hold_cfg = 6;
        set_counted(2, 1);
        begin
            int c = 0;
            while (!(m_hi && !m_idle) && c < 50) begin
                cycle();
                c++;
            end
            if (!(m_hi && !m_idle)) timeout("reset_reach_wait_lo");
        end
        tx_hold_cfg = 2;
        for (int k = 0; k < N; k++) set_counted(k, 1);
        drv_rst = 1;
        cycle();
        #1;
        check("midrst_tx_en", 32'(uart_tx_en), 32'd0);
        check("midrst_tx_data", 32'(uart_tx_data), 32'h0);
        check("midrst_arb_busy", 32'(arb_busy), 32'd0);
        check("midrst_grant_id", 32'(grant_id), 32'd3);
        check("midrst_ready", 32'(req_ready), 32'h0);
        cycle();
        drv_rst = 0;
        start_test();
        run_grants(1, 50, "post_rst");
        check("post_rst_winner", 32'(q_at(0)), 32'd0);
        drain("post_rst_drain");

        // randomized traffic against the model
        rand_mode = 1;
        for (int i = 0; i < 3000; i++) cycle();
        rand_mode = 0;
        drain("random_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
